// File: rtl/csr_regfile.sv
// Control/status register file: CSR read/write, exception entry/return
// bookkeeping, interrupt status and a down-counting timer.
module csr_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic        csr_we,
    input  logic [13:0] csr_num,
    input  logic [31:0] csr_wdata,
    input  logic [31:0] csr_wmask,
    input  logic [13:0] csr_rnum,
    output logic [31:0] csr_rdata,
    input  logic        wb_ex,
    input  logic [5:0]  wb_ecode,
    input  logic [8:0]  wb_esubcode,
    input  logic [31:0] wb_pc,
    input  logic        ertn_flush,
    input  logic [7:0]  hw_int_in,
    output logic [31:0] ex_entry,
    output logic [31:0] era_out,
    output logic        has_int
);

    localparam logic [13:0] ADDR_CRMD   = 14'h000;
    localparam logic [13:0] ADDR_PRMD   = 14'h001;
    localparam logic [13:0] ADDR_ECFG   = 14'h004;
    localparam logic [13:0] ADDR_ESTAT  = 14'h005;
    localparam logic [13:0] ADDR_ERA    = 14'h006;
    localparam logic [13:0] ADDR_EENTRY = 14'h00C;
    localparam logic [13:0] ADDR_SAVE0  = 14'h030;
    localparam logic [13:0] ADDR_SAVE1  = 14'h031;
    localparam logic [13:0] ADDR_SAVE2  = 14'h032;
    localparam logic [13:0] ADDR_SAVE3  = 14'h033;
    localparam logic [13:0] ADDR_TID    = 14'h040;
    localparam logic [13:0] ADDR_TCFG   = 14'h041;
    localparam logic [13:0] ADDR_TVAL   = 14'h042;
    localparam logic [13:0] ADDR_TICLR  = 14'h044;

    logic [8:0]  crmd_q, crmd_d;
    logic [2:0]  prmd_q, prmd_d;
    logic [12:0] ecfg_q, ecfg_d;
    logic [1:0]  estat_sw_q, estat_sw_d;
    logic [7:0]  estat_hw_q, estat_hw_d;
    logic        estat_ti_q, estat_ti_d;
    logic [5:0]  estat_ecode_q, estat_ecode_d;
    logic [8:0]  estat_esub_q, estat_esub_d;
    logic [31:0] era_q, era_d;
    logic [25:0] eentry_q, eentry_d;
    logic [31:0] save_q [4];
    logic [31:0] save_d [4];
    logic [31:0] tid_q, tid_d;
    logic [31:0] tcfg_q, tcfg_d;
    logic [31:0] tval_q, tval_d;

    logic [31:0] estat_full;
    logic        wr_en;
    logic [31:0] wr_bits;
    logic [31:0] wr_val;
    logic        tcfg_wr;
    logic        timer_run;
    logic        timer_fire;

    assign estat_full = {1'b0, estat_esub_q, estat_ecode_q, 4'b0000,
                         estat_ti_q, 1'b0, estat_hw_q, estat_sw_q};

    function automatic logic [31:0] csr_value(input logic [13:0] addr);
        logic [31:0] v;
        v = 32'h0;
        case (addr)
            ADDR_CRMD:   v = {23'h0, crmd_q};
            ADDR_PRMD:   v = {29'h0, prmd_q};
            ADDR_ECFG:   v = {19'h0, ecfg_q};
            ADDR_ESTAT:  v = estat_full;
            ADDR_ERA:    v = era_q;
            ADDR_EENTRY: v = {eentry_q, 6'h00};
            ADDR_SAVE0:  v = save_q[0];
            ADDR_SAVE1:  v = save_q[1];
            ADDR_SAVE2:  v = save_q[2];
            ADDR_SAVE3:  v = save_q[3];
            ADDR_TID:    v = tid_q;
            ADDR_TCFG:   v = tcfg_q;
            ADDR_TVAL:   v = tval_q;
            default:     v = 32'h0;
        endcase
        return v;
    endfunction

    assign csr_rdata = csr_value(csr_rnum);
    assign ex_entry  = {eentry_q, 6'h00};
    assign era_out   = era_q;
    assign has_int   = crmd_q[2] & (|(estat_full[12:0] & ecfg_q));

    // A software write is dropped entirely whenever an exception or ertn commits.
    assign wr_en      = csr_we & ~wb_ex & ~ertn_flush;
    assign wr_bits    = csr_wdata & csr_wmask;
    assign wr_val     = (csr_value(csr_num) & ~csr_wmask) | wr_bits;
    assign tcfg_wr    = wr_en && (csr_num == ADDR_TCFG);
    assign timer_run  = tcfg_q[0] && (tval_q != 32'h0) && !tcfg_wr;
    assign timer_fire = timer_run && (tval_q == 32'h1);

    always_comb begin
        crmd_d        = crmd_q;
        prmd_d        = prmd_q;
        ecfg_d        = ecfg_q;
        estat_sw_d    = estat_sw_q;
        estat_hw_d    = hw_int_in;
        estat_ti_d    = estat_ti_q;
        estat_ecode_d = estat_ecode_q;
        estat_esub_d  = estat_esub_q;
        era_d         = era_q;
        eentry_d      = eentry_q;
        for (int i = 0; i < 4; i++) save_d[i] = save_q[i];
        tid_d         = tid_q;
        tcfg_d        = tcfg_q;
        tval_d        = tval_q;

        if (wb_ex) begin
            prmd_d        = crmd_q[2:0];
            crmd_d[2:0]   = 3'b000;
            era_d         = wb_pc;
            estat_ecode_d = wb_ecode;
            estat_esub_d  = wb_esubcode;
        end else if (ertn_flush) begin
            crmd_d[2:0] = prmd_q;
        end else if (wr_en) begin
            case (csr_num)
                ADDR_CRMD:   crmd_d      = wr_val[8:0];
                ADDR_PRMD:   prmd_d      = wr_val[2:0];
                ADDR_ECFG:   ecfg_d      = wr_val[12:0];
                ADDR_ESTAT:  estat_sw_d  = wr_val[1:0];
                ADDR_ERA:    era_d       = wr_val;
                ADDR_EENTRY: eentry_d    = wr_val[31:6];
                ADDR_SAVE0:  save_d[0]   = wr_val;
                ADDR_SAVE1:  save_d[1]   = wr_val;
                ADDR_SAVE2:  save_d[2]   = wr_val;
                ADDR_SAVE3:  save_d[3]   = wr_val;
                ADDR_TID:    tid_d       = wr_val;
                ADDR_TCFG: begin
                    tcfg_d = wr_val;
                    if (wr_bits[0]) tval_d = {wr_val[31:2], 2'b00};
                end
                ADDR_TICLR: begin
                    if (wr_bits[0]) estat_ti_d = 1'b0;
                end
                default: ;
            endcase
        end

        // Placed after the write decode so a timer set beats a same-cycle TICLR.
        if (timer_run) begin
            if (timer_fire) begin
                estat_ti_d = 1'b1;
                tval_d     = tcfg_q[1] ? {tcfg_q[31:2], 2'b00} : 32'h0;
            end else begin
                tval_d = tval_q - 32'h1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            crmd_q        <= 9'h008;
            prmd_q        <= '0;
            ecfg_q        <= '0;
            estat_sw_q    <= '0;
            estat_hw_q    <= hw_int_in;
            estat_ti_q    <= 1'b0;
            estat_ecode_q <= '0;
            estat_esub_q  <= '0;
            era_q         <= '0;
            eentry_q      <= '0;
            for (int i = 0; i < 4; i++) save_q[i] <= '0;
            tid_q         <= '0;
            tcfg_q        <= '0;
            tval_q        <= '0;
        end else begin
            crmd_q        <= crmd_d;
            prmd_q        <= prmd_d;
            ecfg_q        <= ecfg_d;
            estat_sw_q    <= estat_sw_d;
            estat_hw_q    <= estat_hw_d;
            estat_ti_q    <= estat_ti_d;
            estat_ecode_q <= estat_ecode_d;
            estat_esub_q  <= estat_esub_d;
            era_q         <= era_d;
            eentry_q      <= eentry_d;
            for (int i = 0; i < 4; i++) save_q[i] <= save_d[i];
            tid_q         <= tid_d;
            tcfg_q        <= tcfg_d;
            tval_q        <= tval_d;
        end
    end

endmodule

// File: tb/tb_csr_regfile.sv
// Directed bench for csr_regfile: write/readback vector table plus
// sequences for exception/return, priority, timer, interrupts and reset.
module tb_csr_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wdata;
    logic [31:0] csr_wmask;
    logic [13:0] csr_rnum;
    logic [31:0] csr_rdata;
    logic        wb_ex;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_pc;
    logic        ertn_flush;
    logic [7:0]  hw_int_in;
    logic [31:0] ex_entry;
    logic [31:0] era_out;
    logic        has_int;

    int total = 0;
    int bad   = 0;

    csr_regfile dut (
        .clk(clk), .reset(reset), .csr_we(csr_we), .csr_num(csr_num),
        .csr_wdata(csr_wdata), .csr_wmask(csr_wmask), .csr_rnum(csr_rnum),
        .csr_rdata(csr_rdata), .wb_ex(wb_ex), .wb_ecode(wb_ecode),
        .wb_esubcode(wb_esubcode), .wb_pc(wb_pc), .ertn_flush(ertn_flush),
        .hw_int_in(hw_int_in), .ex_entry(ex_entry), .era_out(era_out),
        .has_int(has_int)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [13:0] num;
        logic [31:0] wdata;
        logic [31:0] wmask;
        logic [13:0] rnum;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [13:0] a, output logic [31:0] d);
        csr_rnum = a;
        #1;
        d = csr_rdata;
    endtask

    task automatic chk_csr(input string name, input logic [13:0] a, input logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        check(name, d, exp);
    endtask

    task automatic wr(input logic [13:0] a, input logic [31:0] d, input logic [31:0] m);
        csr_we = 1'b1; csr_num = a; csr_wdata = d; csr_wmask = m;
        tick();
        csr_we = 1'b0;
    endtask

    initial begin
        logic [31:0] d;

        vecs[0]  = '{1'b1, 14'h030, 32'hDEADBEEF, 32'hFFFFFFFF, 14'h030, 32'hDEADBEEF};
        vecs[1]  = '{1'b1, 14'h030, 32'h0000FFFF, 32'h000000FF, 14'h030, 32'hDEADBEFF};
        vecs[2]  = '{1'b1, 14'h000, 32'hFFFFFFFF, 32'hFFFFFFFF, 14'h000, 32'h000001FF};
        vecs[3]  = '{1'b1, 14'h000, 32'h00000000, 32'h00000003, 14'h000, 32'h000001FC};
        vecs[4]  = '{1'b1, 14'h001, 32'hFFFFFFFF, 32'hFFFFFFFF, 14'h001, 32'h00000007};
        vecs[5]  = '{1'b1, 14'h004, 32'hFFFFFFFF, 32'hFFFFFFFF, 14'h004, 32'h00001FFF};
        vecs[6]  = '{1'b1, 14'h004, 32'h00000000, 32'h00001000, 14'h004, 32'h00000FFF};
        vecs[7]  = '{1'b1, 14'h00C, 32'hFFFFFFFF, 32'hFFFFFFFF, 14'h00C, 32'hFFFFFFC0};
        vecs[8]  = '{1'b1, 14'h042, 32'h00001234, 32'hFFFFFFFF, 14'h042, 32'h00000000};
        vecs[9]  = '{1'b1, 14'h007, 32'hFFFFFFFF, 32'hFFFFFFFF, 14'h007, 32'h00000000};
        vecs[10] = '{1'b1, 14'h005, 32'hFFFFFFFF, 32'hFFFFFFFF, 14'h005, 32'h00000003};
        vecs[11] = '{1'b1, 14'h005, 32'h00000000, 32'h00000003, 14'h005, 32'h00000000};
        vecs[12] = '{1'b1, 14'h040, 32'h12345678, 32'hFFFFFFFF, 14'h040, 32'h12345678};
        vecs[13] = '{1'b1, 14'h044, 32'h00000001, 32'hFFFFFFFF, 14'h044, 32'h00000000};
        vecs[14] = '{1'b1, 14'h033, 32'hCAFEF00D, 32'hFFFFFFFF, 14'h033, 32'hCAFEF00D};
        vecs[15] = '{1'b0, 14'h033, 32'h00000000, 32'hFFFFFFFF, 14'h033, 32'hCAFEF00D};
        vecs[16] = '{1'b1, 14'h004, 32'h00000000, 32'hFFFFFFFF, 14'h031, 32'h00000000};
        vecs[17] = '{1'b1, 14'h001, 32'h00000000, 32'hFFFFFFFF, 14'h001, 32'h00000000};

        reset = 1'b1; csr_we = 1'b0; csr_num = '0; csr_wdata = '0; csr_wmask = '0;
        csr_rnum = '0; wb_ex = 1'b0; wb_ecode = '0; wb_esubcode = '0; wb_pc = '0;
        ertn_flush = 1'b0; hw_int_in = '0;
        tick(); tick();
        reset = 1'b0;
        tick();

        chk_csr("reset_crmd", 14'h000, 32'h00000008);
        chk_csr("reset_tcfg", 14'h041, 32'h0);
        chk_csr("reset_tval", 14'h042, 32'h0);
        chk_csr("reset_estat", 14'h005, 32'h0);
        check("reset_has_int", {31'h0, has_int}, 32'h0);
        check("reset_ex_entry", ex_entry, 32'h0);
        check("reset_era_out", era_out, 32'h0);

        for (int i = 0; i < 18; i++) begin
            csr_we = vecs[i].we; csr_num = vecs[i].num;
            csr_wdata = vecs[i].wdata; csr_wmask = vecs[i].wmask;
            tick();
            csr_we = 1'b0;
            rd(vecs[i].rnum, d);
            check($sformatf("vec%0d", i), d, vecs[i].exp);
        end
        check("ex_entry", ex_entry, 32'hFFFFFFC0);

        // same-cycle read and write returns the old value
        csr_we = 1'b1; csr_num = 14'h032; csr_wdata = 32'h11112222; csr_wmask = 32'hFFFFFFFF;
        rd(14'h032, d);
        check("rw_no_bypass", d, 32'h0);
        tick();
        csr_we = 1'b0;
        chk_csr("rw_after", 14'h032, 32'h11112222);

        // exception entry and return
        wr(14'h000, 32'h7, 32'hFFFFFFFF);
        chk_csr("crmd_set7", 14'h000, 32'h7);
        wb_ex = 1'b1; wb_ecode = 6'h0B; wb_esubcode = 9'h0; wb_pc = 32'h1C000100;
        tick();
        wb_ex = 1'b0;
        chk_csr("ex_crmd", 14'h000, 32'h0);
        chk_csr("ex_prmd", 14'h001, 32'h7);
        chk_csr("ex_era", 14'h006, 32'h1C000100);
        check("ex_era_out", era_out, 32'h1C000100);
        chk_csr("ex_estat", 14'h005, 32'h000B0000);
        ertn_flush = 1'b1;
        tick();
        ertn_flush = 1'b0;
        chk_csr("ertn_crmd", 14'h000, 32'h7);

        // wb_ex beats a same-cycle ERA write
        wb_ex = 1'b1; wb_ecode = 6'h08; wb_esubcode = 9'h3; wb_pc = 32'h00002000;
        csr_we = 1'b1; csr_num = 14'h006; csr_wdata = 32'h1234; csr_wmask = 32'hFFFFFFFF;
        tick();
        wb_ex = 1'b0; csr_we = 1'b0;
        chk_csr("prio_era", 14'h006, 32'h00002000);
        chk_csr("prio_estat", 14'h005, 32'h00C80000);
        chk_csr("prio_crmd", 14'h000, 32'h0);

        // ertn beats a same-cycle SAVE1 write
        ertn_flush = 1'b1;
        csr_we = 1'b1; csr_num = 14'h031; csr_wdata = 32'h55; csr_wmask = 32'hFFFFFFFF;
        tick();
        ertn_flush = 1'b0; csr_we = 1'b0;
        chk_csr("ertn_drop_save1", 14'h031, 32'h0);
        chk_csr("ertn_crmd2", 14'h000, 32'h7);

        // one-shot timer
        wr(14'h041, 32'h00000009, 32'hFFFFFFFF);
        chk_csr("tval_load", 14'h042, 32'h8);
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk_csr($sformatf("tval_dec%0d", i), 14'h042, 32'(8 - i));
            rd(14'h005, d);
            check($sformatf("ti_dec%0d", i), {31'h0, d[11]}, (i == 8) ? 32'h1 : 32'h0);
        end
        tick(); tick(); tick();
        chk_csr("tval_hold0", 14'h042, 32'h0);
        check("has_int_ecfg0", {31'h0, has_int}, 32'h0);

        // interrupt enable and clear
        wr(14'h004, 32'h00000800, 32'hFFFFFFFF);
        check("has_int_on", {31'h0, has_int}, 32'h1);
        wr(14'h044, 32'h00000001, 32'hFFFFFFFF);
        rd(14'h005, d);
        check("ticlr_ti", {31'h0, d[11]}, 32'h0);
        check("has_int_off", {31'h0, has_int}, 32'h0);
        tick(); tick(); tick();
        rd(14'h005, d);
        check("no_refire", {31'h0, d[11]}, 32'h0);

        // periodic timer; timer set beats a same-cycle TICLR
        wr(14'h041, 32'h00000007, 32'hFFFFFFFF);
        chk_csr("per_load", 14'h042, 32'h4);
        tick(); tick(); tick();
        chk_csr("per_at1", 14'h042, 32'h1);
        wr(14'h044, 32'h00000001, 32'hFFFFFFFF);
        chk_csr("per_reload", 14'h042, 32'h4);
        rd(14'h005, d);
        check("set_beats_clr", {31'h0, d[11]}, 32'h1);
        check("has_int_per", {31'h0, has_int}, 32'h1);

        // reset mid-operation with wb_ex and hw interrupts asserted
        tick();
        reset = 1'b1; wb_ex = 1'b1; wb_pc = 32'hABCD0000; hw_int_in = 8'h3C;
        tick();
        reset = 1'b0; wb_ex = 1'b0;
        chk_csr("rst_crmd", 14'h000, 32'h8);
        chk_csr("rst_tval", 14'h042, 32'h0);
        chk_csr("rst_tcfg", 14'h041, 32'h0);
        chk_csr("rst_era", 14'h006, 32'h0);
        chk_csr("rst_estat_hw", 14'h005, 32'h000000F0);
        check("rst_era_out", era_out, 32'h0);
        check("rst_ex_entry", ex_entry, 32'h0);
        check("rst_has_int", {31'h0, has_int}, 32'h0);
        hw_int_in = 8'h00;
        tick();
        chk_csr("hw_follow", 14'h005, 32'h0);
        chk_csr("rst_save0", 14'h030, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/csr_regfile.md
CSR_REGFILE -- requirements
Module: csr_regfile

Interface
REQ-001 SHALL have port: clk  input  1  single clock for the block; all state updates on its rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset, sampled on the clk rising edge.
REQ-003 SHALL have port: csr_we  input  1  CSR write commit from write-back; already qualified by the write-back valid bit.
REQ-004 SHALL have port: csr_num  input  14  CSR address of the write.
REQ-005 SHALL have port: csr_wdata  input  32  write data.
REQ-006 SHALL have port: csr_wmask  input  32  bit mask; 1 = bit takes csr_wdata, 0 = bit keeps its old value (all-ones for csrwr).
REQ-007 SHALL have port: csr_rnum  input  14  read address (decode stage).
REQ-008 SHALL have port: csr_rdata  output  32  read data.
REQ-009 SHALL have port: wb_ex  input  1  exception commit from write-back.
REQ-010 SHALL have port: wb_ecode  input  6  exception code.
REQ-011 SHALL have port: wb_esubcode  input  9  exception sub-code.
REQ-012 SHALL have port: wb_pc  input  32  PC of the excepting instruction.
REQ-013 SHALL have port: ertn_flush  input  1  ertn commit from write-back.
REQ-014 SHALL have port: hw_int_in  input  8  level hardware interrupt lines.
REQ-015 SHALL have port: ex_entry  output  32  exception entry address (EENTRY).
REQ-016 SHALL have port: era_out  output  32  return address (ERA).
REQ-017 SHALL have port: has_int  output  1  interrupt pending and enabled.

Function
REQ-018 Registers and addresses SHALL be: CRMD 0x0, PRMD 0x1, ECFG 0x4, ESTAT 0x5, ERA 0x6, EENTRY 0xC, SAVE0-3 0x30-0x33, TID 0x40, TCFG 0x41, TVAL 0x42, TICLR 0x44.
REQ-019 Writable fields SHALL be:
- CRMD[8:0] (PLV[1:0], IE[2], DA[3], PG[4], DATF[6:5], DATM[8:7])
- PRMD[2:0] (PPLV[1:0], PIE[2])
- ECFG[12:0] (LIE)
- ESTAT[1:0] (software interrupts)
- ERA[31:0], EENTRY[31:6], SAVE0-3[31:0], TID[31:0], TCFG[31:0] (En[0], Periodic[1], InitVal[31:2])
- All other bits SHALL read 0.
REQ-020 On csr_we, the addressed writable field SHALL update the next cycle to (old & ~csr_wmask) | (csr_wdata & csr_wmask).
REQ-021 Writes to TVAL, to unmapped addresses and to read-only bits SHALL be ignored.
REQ-022 csr_rdata SHALL be combinational from csr_rnum, with 0 for unmapped addresses and for TICLR.
REQ-023 A read and a write to the same CSR in the same cycle SHALL return the old value (no bypass).
REQ-024 On wb_ex, the next cycle SHALL have:
- PRMD.PPLV = CRMD.PLV
- PRMD.PIE = CRMD.IE
- CRMD.PLV = 0
- CRMD.IE = 0
- ERA = wb_pc
- ESTAT[21:16] = wb_ecode
- ESTAT[30:22] = wb_esubcode
REQ-025 On ertn_flush, the next cycle SHALL have CRMD.PLV = PRMD.PPLV and CRMD.IE = PRMD.PIE.
REQ-026 Priority SHALL be wb_ex > ertn_flush > csr_we; the lower-priority commit in the same cycle SHALL be dropped entirely.
REQ-027 ESTAT[9:2] SHALL be loaded from hw_int_in every cycle.
REQ-028 A write to TCFG with csr_wdata&csr_wmask bit0 = 1 SHALL load TVAL = {new InitVal, 2'b00}.
REQ-029 Timer decrement SHALL behave as follows:
- While TCFG.En = 1 and TVAL != 0 with no TCFG write, TVAL SHALL decrement by 1 per cycle.
- When TVAL = 1, ESTAT[11] SHALL be set in the same update.
- On that update, TVAL SHALL reload {InitVal, 2'b00} if Periodic = 1, otherwise become 0.
- TVAL = 0 with En = 1 SHALL hold and raise no further interrupt.
REQ-030 A write with bit0 = 1 to TICLR SHALL clear ESTAT[11]; a timer set in the same cycle SHALL win.
REQ-031 has_int SHALL equal CRMD.IE & |(ESTAT[12:0] & ECFG[12:0]), combinational from registered state.
REQ-032 ex_entry SHALL equal EENTRY and era_out SHALL equal ERA, both combinational.

Reset
REQ-033 Reset SHALL set CRMD = 0x0000_0008 (DA = 1, PLV = 0, IE = 0) and TCFG.En = 0.
REQ-034 Reset SHALL clear all other registers to 0, except ESTAT[9:2], which SHALL keep following hw_int_in.
REQ-035 Reset SHALL override wb_ex, ertn_flush and csr_we in the same cycle.
REQ-036 After reset, has_int SHALL be 0, ex_entry SHALL be 0 and era_out SHALL be 0.

Verification
REQ-037 Write with masks: csrwr 0x30 = 0xDEADBEEF with mask 0xFFFFFFFF, then 0x30 = 0x0000FFFF with mask 0x000000FF -> SAVE0 reads 0xDEADBEFF.
REQ-038 Exception then return:
- Set CRMD = 0x7 (PLV = 3, IE = 1).
- Apply wb_ex with ecode 0x0B and wb_pc 0x1C000100 -> CRMD = 0x0, PRMD = 0x7, ERA = 0x1C000100, ESTAT[21:16] = 0x0B.
- Then apply ertn_flush -> CRMD = 0x7.
REQ-039 Same-cycle wb_ex and csr_we to ERA = 0x1234 -> ERA = wb_pc, write dropped.
REQ-040 One-shot timer: TCFG = 0x0000_0009 (En = 1, InitVal = 2) -> TVAL = 8, reaches 0 after 8 cycles, ESTAT[11] = 1 once, TVAL stays 0.
REQ-041 Interrupt enable: ECFG = 0x800 with CRMD.IE = 1 and the timer fired -> has_int = 1; TICLR write 0x1 -> ESTAT[11] = 0 and has_int = 0 the next cycle.
REQ-042 Reset mid-operation: reset asserted while the periodic timer is running and wb_ex is applied -> CRMD = 0x8, TVAL = 0, TCFG = 0, ERA = 0.
